// File: rtl/fft_bus_pkg.sv
// Shared types and constants for the Avalon-MM sample slave that feeds the FFT core.
// No ports; imported by the interface, the sample RAM and the top.
package fft_bus_pkg;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 512;
   localparam int BUF_AW = 9;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = 10;

   // count saturates at a full buffer, so it needs one bit more than the index
   localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      OKAY        = 2'b00,
      SLVERR      = 2'b10,
      DECODEERROR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 10'h200;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 10'h201;
   localparam logic [ADDR_W-1:0] ADDR_COUNT  = 10'h202;

   localparam int CTRL_START  = 0;
   localparam int CTRL_CLEAR  = 1;

   localparam int STATUS_BUSY = 0;
   localparam int STATUS_DONE = 1;
   localparam int STATUS_OVF  = 2;

endpackage

// File: rtl/avalon_sample_slave_if.sv
// Avalon-MM bus bundle between the host master and the sample slave.
// master modport: drives address/read/write/write_data, receives data, strobes,
//                 response and waitrequest.
// slave modport : the mirror image.
interface avalon_sample_slave_if;
   import fft_bus_pkg::*;

   logic [ADDR_W-1:0] slave_address;
   logic              slave_read;
   logic              slave_write;
   logic [DATA_W-1:0] slave_write_data;
   logic [DATA_W-1:0] slave_read_data;
   logic              slave_readdatavalid;
   logic              slave_writeresponsevalid;
   logic [1:0]        slave_response;
   logic              slave_waitrequest;

   modport master (
      output slave_address, slave_read, slave_write, slave_write_data,
      input  slave_read_data, slave_readdatavalid, slave_writeresponsevalid,
             slave_response, slave_waitrequest
   );

   modport slave (
      input  slave_address, slave_read, slave_write, slave_write_data,
      output slave_read_data, slave_readdatavalid, slave_writeresponsevalid,
             slave_response, slave_waitrequest
   );

endinterface

// File: rtl/sample_ram.sv
// 512x16 sample buffer: one write port, two registered read ports (bus, core).
// Ports: clk, n_rst (clears only the read registers), wr_en/wr_addr/wr_data,
//        bus_rd_addr -> bus_rd_data, core_rd_addr -> core_rd_data (1-cycle latency).
// A read and write of the same index in one cycle returns the old word.
module sample_ram
   import fft_bus_pkg::*;
(
   input  logic              clk,
   input  logic              n_rst,
   input  logic              wr_en,
   input  logic [BUF_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [BUF_AW-1:0] bus_rd_addr,
   output logic [DATA_W-1:0] bus_rd_data,
   input  logic [BUF_AW-1:0] core_rd_addr,
   output logic [DATA_W-1:0] core_rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bus_rd_data  <= '0;
         core_rd_data <= '0;
      end else begin
         bus_rd_data  <= mem[bus_rd_addr];
         core_rd_data <= mem[core_rd_addr];
      end
   end

endmodule

// File: rtl/avalon_sample_slave.sv
// Avalon-MM slave in front of the FFT sample buffer, plus run control.
// Ports: clk, n_rst (async, active-low), bus (Avalon slave modport),
//        fft_rd_addr/fft_rd_data (core read port, 1-cycle latency),
//        fft_start (one-cycle launch pulse), fft_done (core completion pulse).
//
// state | meaning
// IDLE  | no run; buffer writable; waiting for CTRL start
// START | one cycle, fft_start high
// RUN   | core busy; buffer writes stalled; waiting for fft_done
// DONE  | run finished; buffer writable; restart or clear allowed
module avalon_sample_slave
   import fft_bus_pkg::*;
(
   input  logic                clk,
   input  logic                n_rst,
   avalon_sample_slave_if.slave bus,
   input  logic [BUF_AW-1:0]   fft_rd_addr,
   output logic [DATA_W-1:0]   fft_rd_data,
   output logic                fft_start,
   input  logic                fft_done
);

   state_t            state_q, state_d;
   logic              busy;
   logic [CNT_W-1:0]  count_q;
   logic              done_q, ovf_q;
   logic              rd_only, wr_only, rd_wr, accept;
   logic              is_buf, is_ctrl, is_status, is_count;
   logic              buf_wr, ctrl_wr, start_ok, clear_cmd, start_pend_q;
   logic              wr_start_bit, wr_clear_bit;
   resp_t             ctrl_resp, resp_d, resp_q;
   logic              rd_valid_d, wr_valid_d, rd_valid_q, wr_valid_q;
   logic [DATA_W-1:0] status, reg_rdata_d, reg_rdata_q, bus_ram_q;
   logic              sel_buf_q;

   // ---------------- decode ----------------
   assign rd_only   = bus.slave_read & ~bus.slave_write;
   assign wr_only   = bus.slave_write & ~bus.slave_read;
   assign rd_wr     = bus.slave_read & bus.slave_write;
   assign is_buf    = ~bus.slave_address[ADDR_W-1];
   assign is_ctrl   = bus.slave_address == ADDR_CTRL;
   assign is_status = bus.slave_address == ADDR_STATUS;
   assign is_count  = bus.slave_address == ADDR_COUNT;

   assign bus.slave_waitrequest = wr_only & is_buf & busy;
   assign accept  = (bus.slave_read | bus.slave_write) & ~bus.slave_waitrequest;
   assign buf_wr  = accept & wr_only & is_buf;
   assign ctrl_wr = accept & wr_only & is_ctrl;

   assign wr_start_bit = bus.slave_write_data[CTRL_START];
   assign wr_clear_bit = bus.slave_write_data[CTRL_CLEAR];

   // clear takes effect first, so start+clear always sees an empty buffer
   assign clear_cmd = ctrl_wr & ~busy & wr_clear_bit;
   assign start_ok  = ctrl_wr & ~busy & wr_start_bit & ~wr_clear_bit & (count_q != '0);

   always_comb begin
      ctrl_resp = OKAY;
      if (busy) begin
         if (wr_start_bit || wr_clear_bit) ctrl_resp = SLVERR;
      end else if (wr_start_bit && (wr_clear_bit || count_q == '0)) begin
         ctrl_resp = SLVERR;
      end
   end

   always_comb begin
      status              = '0;
      status[STATUS_BUSY] = busy;
      status[STATUS_DONE] = done_q;
      status[STATUS_OVF]  = ovf_q;
   end

   // ---------------- response ----------------
   always_comb begin
      rd_valid_d  = 1'b0;
      wr_valid_d  = 1'b0;
      resp_d      = OKAY;
      reg_rdata_d = '0;
      if (accept) begin
         if (rd_wr) begin
            wr_valid_d = 1'b1;
            resp_d     = SLVERR;
         end else if (rd_only) begin
            rd_valid_d = 1'b1;
            if (is_status) begin
               reg_rdata_d = status;
            end else if (is_count) begin
               reg_rdata_d = {{(DATA_W-CNT_W){1'b0}}, count_q};
            end else if (!is_buf && !is_ctrl) begin
               resp_d = DECODEERROR;
            end
         end else begin
            wr_valid_d = 1'b1;
            if (is_ctrl) begin
               resp_d = ctrl_resp;
            end else if (is_status || is_count) begin
               resp_d = SLVERR;
            end else if (!is_buf) begin
               resp_d = DECODEERROR;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_valid_q   <= 1'b0;
         wr_valid_q   <= 1'b0;
         resp_q       <= OKAY;
         reg_rdata_q  <= '0;
         sel_buf_q    <= 1'b0;
         start_pend_q <= 1'b0;
         count_q      <= '0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         rd_valid_q   <= rd_valid_d;
         wr_valid_q   <= wr_valid_d;
         resp_q       <= resp_d;
         reg_rdata_q  <= reg_rdata_d;
         sel_buf_q    <= is_buf;
         // launch lands one cycle after the CTRL response, alongside it in time
         start_pend_q <= start_ok;
         if (clear_cmd) begin
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
         end else begin
            if (buf_wr) begin
               if (count_q == COUNT_MAX) ovf_q <= 1'b1;
               else                      count_q <= count_q + CNT_W'(1);
            end
            if (state_q == RUN && fft_done) done_q <= 1'b1;
            else if (start_pend_q)          done_q <= 1'b0;
         end
      end
   end

   assign bus.slave_readdatavalid      = rd_valid_q;
   assign bus.slave_writeresponsevalid = wr_valid_q;
   assign bus.slave_response           = resp_q;
   assign bus.slave_read_data = rd_valid_q ? (sel_buf_q ? bus_ram_q : reg_rdata_q) : '0;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start_pend_q) state_d = START;
         START: state_d = RUN;
         RUN:   if (fft_done) state_d = DONE;
         DONE: begin
            if (start_pend_q)   state_d = START;
            else if (clear_cmd) state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      fft_start = (state_q == START);
      busy      = (state_q == START) || (state_q == RUN);
   end

   sample_ram u_ram (
      .clk          (clk),
      .n_rst        (n_rst),
      .wr_en        (buf_wr),
      .wr_addr      (bus.slave_address[BUF_AW-1:0]),
      .wr_data      (bus.slave_write_data),
      .bus_rd_addr  (bus.slave_address[BUF_AW-1:0]),
      .bus_rd_data  (bus_ram_q),
      .core_rd_addr (fft_rd_addr),
      .core_rd_data (fft_rd_data)
   );

endmodule

// File: doc/avalon_sample_slave.md
Name: avalon_sample_slave

Overview:
Avalon-MM slave (responder) that forms the host-facing end of the sample path into the FFT core. The bus master writes time-domain samples into a 512x16 sample buffer and controls the run through CTRL/STATUS registers. The FFT core reads the buffer through a private read port. The block pulses fft_start to launch the core and tracks fft_done.

Parameters:
DATA_W, 16, sample and register data width
DEPTH, 512, sample buffer entries
BUF_AW, 9, buffer index width (log2 DEPTH)
ADDR_W, 10, Avalon word-address width; bit 9 selects register space

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
slave_address  in  ADDR_W  word address
slave_read  in  1  read request
slave_write  in  1  write request
slave_write_data  in  DATA_W  write data
slave_read_data  out  DATA_W  read data, valid with slave_readdatavalid
slave_readdatavalid  out  1  read completion strobe
slave_writeresponsevalid  out  1  write completion strobe
slave_response  out  2  00 OKAY, 10 SLVERR, 11 DECODEERROR; valid with either strobe
slave_waitrequest  out  1  backpressure
fft_rd_addr  in  BUF_AW  core read index
fft_rd_data  out  DATA_W  buffer word, 1-cycle latency
fft_start  out  1  one-cycle launch pulse
fft_done  in  1  core completion pulse

Behaviour:
- Clock and reset: one clock, clk. n_rst is asynchronous and active-low.
- Reset values: all outputs 0; count 0; done 0; ovf 0; state IDLE. Buffer contents are undefined.
- Address map:
  - 0x000-0x1FF: buffer[addr[8:0]], read/write.
  - 0x200 CTRL, write-only: bit0 start, bit1 clear. Reads of CTRL return 0.
  - 0x201 STATUS, read-only: bit0 busy, bit1 done, bit2 ovf.
  - 0x202 COUNT, read-only: count.
  - 0x203-0x3FF: DECODEERROR. Writes to these addresses have no effect and reads return 0.
- Handshake:
  - A request is accepted in the cycle where read or write is high and waitrequest is low.
  - Response timing: slave_readdatavalid or slave_writeresponsevalid, together with slave_response, is driven exactly 1 cycle after acceptance.
  - Back-to-back accepted requests are legal and produce one strobe per cycle.
  - slave_waitrequest is combinational: high only for a buffer write while the state is START or RUN. The master holds the request until waitrequest drops. Register accesses are never stalled.
  - read and write asserted in the same cycle: accepted, no side effect, response SLVERR returned on slave_writeresponsevalid only.
- Buffer writes (accepted): write the word. count increments, saturating at DEPTH. If count==DEPTH before the write, set ovf (sticky); the data is still written.
- Writes to STATUS or COUNT: SLVERR, no effect.
- State machine:
  - IDLE: CTRL write with bit0=1 and count>0 -> START, response OKAY. If count==0, stay in IDLE, response SLVERR.
  - START: one cycle. fft_start=1, busy=1 -> RUN.
  - RUN: busy=1. CTRL start is ignored with response SLVERR. fft_done -> DONE, done=1.
  - DONE: busy=0, buffer writes allowed. CTRL bit0=1 with count>0 -> START.
  - CTRL bit1=1 in IDLE or DONE: count, done and ovf cleared -> IDLE. In RUN it is ignored with response SLVERR. If bit0 and bit1 are both set, clear applies first; start is then rejected with SLVERR because count is 0.
- fft_done outside RUN is ignored.
- Core read port: fft_rd_data = buffer[fft_rd_addr] registered, 1-cycle latency, available in every state. A same-cycle bus write and core read of the same index returns the old data.
- Reset mid-RUN: immediate return to IDLE. A pending response strobe is dropped.

Decomposition:
- Package fft_bus_pkg holds:
  - the resp_t enum (OKAY, SLVERR, DECODEERROR);
  - the state_t enum (IDLE, START, RUN, DONE);
  - the constants ADDR_CTRL, ADDR_STATUS and ADDR_COUNT;
  - the CTRL_START and CTRL_CLEAR bit indices;
  - the STATUS_BUSY, STATUS_DONE and STATUS_OVF bit indices.
- Sub-module sample_ram: 512x16 simple dual-port RAM with one write port and two registered read ports (bus and core). All decoding and the FSM stay in the top.

Test Plan:
- Reset release, then write 0x1234 to 0x005 and read 0x005 -> writeresponsevalid OKAY the next cycle; readdatavalid with 0x1234 and OKAY one cycle after the read; COUNT reads 1.
- Write 4 samples, write CTRL=0x1 -> fft_start high for exactly one cycle, two cycles after the CTRL acceptance; STATUS=0x1. Pulse fft_done -> STATUS=0x2.
- During RUN, write to 0x010 -> waitrequest held high until the cycle after fft_done, then the write is accepted; COUNT becomes 5.
- CTRL=0x1 with COUNT=0 -> SLVERR, no fft_start. Read 0x300 -> DECODEERROR, data 0. Write STATUS -> SLVERR.
- 513 buffer writes -> COUNT=512, STATUS bit2=1. CTRL=0x2 -> COUNT=0, STATUS=0x0.
- Drop n_rst during RUN (asynchronously, mid-cycle) -> all outputs 0 immediately; after release STATUS=0 and fft_done is ignored. A core read of index 5 returns the value last written at 1-cycle latency.
